// File: rtl/morse_decoder.sv
// Morse key front end for the 7-segment driver: synchronize, debounce, time presses, decode one digit.
// Optional MORSE_ERR_EN adds an err output that pulses with flag when the collected code is not a digit.
module morse_decoder #(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
    parameter logic [23:0] DOT_MAX_CYC  = 24'd2500000,
    parameter logic [23:0] GAP_CYC      = 24'd7500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       morse_in,
    output logic [3:0] key,
    output logic       flag,
`ifdef MORSE_ERR_EN
    output logic       err,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    state_t      state, state_next;
    logic        sync_p0, sync_p1;
    logic        deb;
    logic [15:0] deb_cnt;
    logic [23:0] press_cnt;
    logic [23:0] gap_cnt;
    logic [4:0]  sym;
    logic [2:0]  nsym;
    logic        is_dash;
    logic [4:0]  decoded;
    logic        code_ok;
    logic        emit_p0;
`ifdef MORSE_ERR_EN
    logic        err_p0;
`endif

    // Returns {hit, digit}; first symbol sits in the MSB, dash = 1.
    function automatic logic [4:0] decode_digit(input logic [4:0] code);
        case (code)
            5'b11111: return {1'b1, 4'd0};
            5'b01111: return {1'b1, 4'd1};
            5'b00111: return {1'b1, 4'd2};
            5'b00011: return {1'b1, 4'd3};
            5'b00001: return {1'b1, 4'd4};
            5'b00000: return {1'b1, 4'd5};
            5'b10000: return {1'b1, 4'd6};
            5'b11000: return {1'b1, 4'd7};
            5'b11100: return {1'b1, 4'd8};
            5'b11110: return {1'b1, 4'd9};
            default:  return {1'b0, 4'hF};
        endcase
    endfunction

    assign decoded = decode_digit(sym);
    assign code_ok = (nsym == 3'd5) && decoded[4];
    assign is_dash = (press_cnt >= DOT_MAX_CYC);
    assign busy    = (state != IDLE);

    // Stage p0/p1: two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= morse_in;
            sync_p1 <= sync_p0;
        end
    end

    // Debouncer: any cycle agreeing with the current level restarts the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (sync_p1 != deb) begin
            if (deb_cnt == DEBOUNCE_CYC - 16'd1) begin
                deb     <= sync_p1;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 16'd1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (deb) state_next = PRESS;
            PRESS:   if (!deb) state_next = GAP;
            GAP: begin
                if (deb)                                state_next = PRESS;
                else if (gap_cnt == GAP_CYC - 24'd1)    state_next = EMIT;
            end
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Press timing starts at 1: the cycle that moved us into PRESS was already high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_cnt <= '0;
            gap_cnt   <= '0;
            sym       <= '0;
            nsym      <= '0;
        end else begin
            case (state)
                IDLE: if (deb) press_cnt <= 24'd1;
                PRESS: begin
                    if (deb) begin
                        if (press_cnt != '1) press_cnt <= press_cnt + 24'd1;
                    end else begin
                        if (nsym < 3'd5)  sym  <= {sym[3:0], is_dash};
                        if (nsym != 3'd6) nsym <= nsym + 3'd1;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (deb)                           press_cnt <= 24'd1;
                    else if (gap_cnt != GAP_CYC - 24'd1) gap_cnt <= gap_cnt + 24'd1;
                end
                EMIT: begin
                    sym  <= '0;
                    nsym <= '0;
                end
                default: ;
            endcase
        end
    end

    // Stage p0 -> output: key settles one cycle ahead of the flag strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key     <= 4'hF;
            emit_p0 <= 1'b0;
            flag    <= 1'b0;
`ifdef MORSE_ERR_EN
            err_p0  <= 1'b0;
            err     <= 1'b0;
`endif
        end else begin
`ifdef MORSE_ERR_EN
            if (state == EMIT) key <= code_ok ? decoded[3:0] : 4'hF;
            emit_p0 <= (state == EMIT);
            err_p0  <= (state == EMIT) && !code_ok;
            err     <= err_p0;
`else
            if ((state == EMIT) && code_ok) key <= decoded[3:0];
            emit_p0 <= (state == EMIT) && code_ok;
`endif
            flag <= emit_p0;
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed scenarios plus random digits against a string-level Morse model.
module tb_morse_decoder;

    localparam int DEB_I = 4;
    localparam int DOT_I = 20;
    localparam int GAP_I = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       morse_in = 1'b0;
    logic [3:0] key;
    logic       flag;
    logic       busy;
`ifdef MORSE_ERR_EN
    logic       err;
`endif

    morse_decoder #(
        .DEBOUNCE_CYC(16'd4),
        .DOT_MAX_CYC (24'd20),
        .GAP_CYC     (24'd40)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .morse_in(morse_in),
        .key     (key),
        .flag    (flag),
`ifdef MORSE_ERR_EN
        .err     (err),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    // Observation of DUT outputs on the falling edge
    int         flag_cnt = 0;
    int         flag_cyc = 0;
    int         wide_cnt = 0;
    int         busy_hi = 0;
    int         err_cnt = 0;
    int         err_lone = 0;
    logic       flag_q = 1'b0;
    logic [3:0] key_prev = 4'hF;
    logic [3:0] key_before = 4'hF;
    int         rel_cyc = 0;

    always @(negedge clk) begin
        if (flag === 1'b1) begin
            flag_cnt++;
            flag_cyc = cyc;
            key_before = key_prev;
            if (flag_q) wide_cnt++;
        end
        flag_q = (flag === 1'b1);
        key_prev = key;
        if (busy === 1'b1) busy_hi++;
`ifdef MORSE_ERR_EN
        if (err === 1'b1) begin
            err_cnt++;
            if (flag !== 1'b1) err_lone++;
        end
`endif
    end

    // Reference model: standard Morse digit strings, compared as text
    function automatic string morse_str(input int dg);
        string r = "";
        string dot_s = ".";
        string dash_s = "-";
        for (int i = 0; i < 5; i++) begin
            bit is_dot;
            if (dg >= 1 && dg <= 5) is_dot = (i < dg);
            else if (dg >= 6)       is_dot = (i >= dg - 5);
            else                    is_dot = 1'b0;
            r = is_dot ? {r, dot_s} : {r, dash_s};
        end
        return r;
    endfunction

    function automatic int ref_digit(input int d[8], input int n);
        string s = "";
        string dot_s = ".";
        string dash_s = "-";
        for (int i = 0; i < n; i++) s = (d[i] >= DOT_I) ? {s, dash_s} : {s, dot_s};
        if (n != 5) return -1;
        for (int dg = 0; dg < 10; dg++) if (s == morse_str(dg)) return dg;
        return -1;
    endfunction

    task automatic press(input int dur, input int gap);
        morse_in = 1'b1;
        repeat (dur) @(negedge clk);
        morse_in = 1'b0;
        rel_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_char(input int d[8], input int n, output int nf, output logic [3:0] ks,
                            output logic [3:0] kb, output logic [3:0] ka, output int lat,
                            output int nw, output int ne, output logic ba);
        int f0, w0, e0;
        f0 = flag_cnt; w0 = wide_cnt; e0 = err_cnt; ks = key;
        for (int i = 0; i < n; i++) press(d[i], (i == n - 1) ? 0 : int'($urandom_range(8, 15)));
        repeat (100) @(negedge clk);
        nf = flag_cnt - f0; nw = wide_cnt - w0; ne = err_cnt - e0;
        kb = key_before; ka = key; lat = flag_cyc - rel_cyc; ba = busy;
    endtask

    task automatic test_reset();
        nvec++; if (key !== 4'hF) begin nerr++; $display("FAIL reset_key: got %h want f", key); end
        nvec++; if (flag !== 1'b0) begin nerr++; $display("FAIL reset_flag: got %b want 0", flag); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_digit_2();
        int d[8] = '{10, 10, 30, 30, 30, 0, 0, 0};
        int nf, lat, nw, ne; logic [3:0] ks, kb, ka; logic ba;
        run_char(d, 5, nf, ks, kb, ka, lat, nw, ne, ba);
        nvec++; if (nf !== 1) begin nerr++; $display("FAIL d2_flags: got %0d want 1", nf); end
        nvec++; if (kb !== 4'h2) begin nerr++; $display("FAIL d2_key_before_flag: got %h want 2", kb); end
        nvec++; if (ka !== 4'h2) begin nerr++; $display("FAIL d2_key_hold: got %h want 2", ka); end
        nvec++; if (lat < GAP_I || lat > GAP_I + DEB_I + 10) begin nerr++; $display("FAIL d2_latency: got %0d want %0d..%0d", lat, GAP_I, GAP_I + DEB_I + 10); end
        nvec++; if (nw !== 0) begin nerr++; $display("FAIL d2_flag_width: got %0d wide want 0", nw); end
        nvec++; if (ba !== 1'b0) begin nerr++; $display("FAIL d2_busy_after: got %b want 0", ba); end
    endtask

    task automatic test_back_to_back();
        int d[8];
        int nf, lat, nw, ne; logic [3:0] ks, kb, ka, ex; logic ba;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin d = '{30, 30, 30, 30, 30, 0, 0, 0}; ex = 4'h0; end
            else        begin d = '{10, 10, 10, 10, 10, 0, 0, 0}; ex = 4'h5; end
            run_char(d, 5, nf, ks, kb, ka, lat, nw, ne, ba);
            nvec++; if (nf !== 1) begin nerr++; $display("FAIL b2b%0d_flags: got %0d want 1", c, nf); end
            nvec++; if (kb !== ex) begin nerr++; $display("FAIL b2b%0d_key: got %h want %h", c, kb, ex); end
            nvec++; if (nw !== 0) begin nerr++; $display("FAIL b2b%0d_flag_width: got %0d want 0", c, nw); end
        end
    endtask

    task automatic test_dash_boundary();
        int d[8];
        int nf, lat, nw, ne; logic [3:0] ks, kb, ka, ex; logic ba;
        for (int c = 0; c < 2; c++) begin
            d = '{10, 10, 10, 10, 0, 0, 0, 0};
            d[4] = (c == 0) ? DOT_I : DOT_I - 1;
            ex = (c == 0) ? 4'h4 : 4'h5;
            run_char(d, 5, nf, ks, kb, ka, lat, nw, ne, ba);
            nvec++; if (nf !== 1) begin nerr++; $display("FAIL bound%0d_flags: got %0d want 1", c, nf); end
            nvec++; if (kb !== ex) begin nerr++; $display("FAIL bound%0d_key: got %h want %h", c, kb, ex); end
        end
    endtask

    task automatic test_bounce();
        int f0, b0;
        f0 = flag_cnt; b0 = busy_hi;
        for (int i = 0; i < 25; i++) begin
            morse_in = ~morse_in;
            repeat (2) @(negedge clk);
        end
        morse_in = 1'b0;
        repeat (60) @(negedge clk);
        nvec++; if (busy_hi - b0 !== 0) begin nerr++; $display("FAIL bounce_busy: got %0d busy cycles want 0", busy_hi - b0); end
        nvec++; if (flag_cnt - f0 !== 0) begin nerr++; $display("FAIL bounce_flags: got %0d want 0", flag_cnt - f0); end
    endtask

    task automatic test_invalid();
        int d[8];
        int nf, lat, nw, ne; logic [3:0] ks, kb, ka; logic ba;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin d = '{10, 10, 10, 0, 0, 0, 0, 0}; run_char(d, 3, nf, ks, kb, ka, lat, nw, ne, ba); end
            else        begin d = '{30, 30, 30, 30, 30, 30, 0, 0}; run_char(d, 6, nf, ks, kb, ka, lat, nw, ne, ba); end
`ifdef MORSE_ERR_EN
            nvec++; if (nf !== 1) begin nerr++; $display("FAIL inv%0d_flags: got %0d want 1", c, nf); end
            nvec++; if (ka !== 4'hF) begin nerr++; $display("FAIL inv%0d_key: got %h want f", c, ka); end
            nvec++; if (ne !== 1 || err_lone !== 0) begin nerr++; $display("FAIL inv%0d_err: got %0d pulses, %0d unaligned want 1,0", c, ne, err_lone); end
`else
            nvec++; if (nf !== 0) begin nerr++; $display("FAIL inv%0d_flags: got %0d want 0", c, nf); end
            nvec++; if (ka !== ks) begin nerr++; $display("FAIL inv%0d_key: got %h want %h", c, ka, ks); end
`endif
            nvec++; if (ba !== 1'b0) begin nerr++; $display("FAIL inv%0d_busy_after: got %b want 0", c, ba); end
        end
    endtask

    task automatic test_reset_mid_char();
        int d[8] = '{30, 30, 30, 30, 10, 0, 0, 0};
        int nf, lat, nw, ne, f0; logic [3:0] ks, kb, ka; logic ba;
        press(30, 12); press(30, 12); press(30, 5);
        f0 = flag_cnt;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy: got %b want 0", busy); end
        nvec++; if (key !== 4'hF) begin nerr++; $display("FAIL midrst_key: got %h want f", key); end
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        nvec++; if (flag_cnt - f0 !== 0) begin nerr++; $display("FAIL midrst_partial_flag: got %0d want 0", flag_cnt - f0); end
        run_char(d, 5, nf, ks, kb, ka, lat, nw, ne, ba);
        nvec++; if (nf !== 1) begin nerr++; $display("FAIL midrst_flags: got %0d want 1", nf); end
        nvec++; if (kb !== 4'h9) begin nerr++; $display("FAIL midrst_key9: got %h want 9", kb); end
    endtask

    task automatic test_random();
        int d[8];
        int n, ex, nf, lat, nw, ne; logic [3:0] ks, kb, ka; logic ba;
        string m;
        for (int it = 0; it < 12; it++) begin
            d = '{0, 0, 0, 0, 0, 0, 0, 0};
            if ($urandom_range(0, 3) != 0) begin
                m = morse_str(int'($urandom_range(0, 9)));
                n = 5;
                for (int i = 0; i < 5; i++)
                    d[i] = (m[i] == "-") ? int'($urandom_range(DOT_I, 35)) : int'($urandom_range(5, DOT_I - 1));
            end else begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) d[i] = $urandom_range(5, 35);
            end
            ex = ref_digit(d, n);
            run_char(d, n, nf, ks, kb, ka, lat, nw, ne, ba);
            if (ex >= 0) begin
                nvec++; if (nf !== 1) begin nerr++; $display("FAIL rnd%0d_flags: got %0d want 1", it, nf); end
                nvec++; if (kb !== 4'(ex)) begin nerr++; $display("FAIL rnd%0d_key: got %h want %h", it, kb, 4'(ex)); end
                nvec++; if (lat < GAP_I || lat > GAP_I + DEB_I + 10) begin nerr++; $display("FAIL rnd%0d_latency: got %0d", it, lat); end
            end else begin
`ifdef MORSE_ERR_EN
                nvec++; if (nf !== 1 || ka !== 4'hF || ne !== 1) begin nerr++; $display("FAIL rnd%0d_invalid: got flags %0d key %h err %0d want 1 f 1", it, nf, ka, ne); end
`else
                nvec++; if (nf !== 0 || ka !== ks) begin nerr++; $display("FAIL rnd%0d_invalid: got flags %0d key %h want 0 %h", it, nf, ka, ks); end
`endif
            end
            nvec++; if (nw !== 0 || ba !== 1'b0) begin nerr++; $display("FAIL rnd%0d_tail: got wide %0d busy %b want 0 0", it, nw, ba); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_digit_2();
        test_back_to_back();
        test_dash_boundary();
        test_bounce();
        test_invalid();
        test_reset_mid_char();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
